fifo_wr_sched: RTL and testbench
================================

Name: fifo_wr_sched

Overview:
Write-side scheduler for the bridge's asynchronous command/data FIFO, running in the wclk (AHB) domain. It shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration. A packet is admitted only when the FIFO reports enough free space for the whole packet, so packets are never split or stalled mid-way. Each FIFO word is tagged with the source ID and an end-of-packet bit for the APB-side consumer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, payload width per word
FIFO_DEPTH, 16, depth of the attached FIFO (power of 2)
MAX_BURST, 16, maximum packet length in words; must be <= FIFO_DEPTH
(derived) IDW = $clog2(NUM_REQ); LENW = $clog2(MAX_BURST)+1; SPW = $clog2(FIFO_DEPTH)+1

Ports:
wclk  in  1  write-domain clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_len  in  NUM_REQ*LENW  packet length in words; sampled at grant
req_data  in  NUM_REQ*DATA_WIDTH  per-requester payload (slice i = requester i)
req_ready  out  NUM_REQ  per-requester word accepted
fifo_full  in  1  FIFO full flag
fifo_sp  in  SPW  FIFO free space in words (conservative)
fifo_wen  out  1  FIFO write enable
fifo_wdata  out  DATA_WIDTH+IDW+1  {id, eop, data}
gnt_id  out  IDW  currently granted requester
busy  out  1  packet transfer in progress
err  out  1  sticky illegal-length flag
err_clr  in  1  clears err (single-cycle pulse)

Behaviour:
- Reset (async assert, sync to wclk on release): state=IDLE; rr_ptr=0; word count=0; outputs req_ready=0, fifo_wen=0, gnt_id=0, busy=0, err=0, fifo_wdata=0.
- FSM states: IDLE, XFER.
- IDLE: the round-robin winner W is the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - If W's effective length L <= fifo_sp, register gnt_id=W and len=L, clear the count, and move to XFER on the next edge (1-cycle grant latency).
  - Otherwise stay in IDLE holding W as candidate. No skipping to a smaller packet (no starvation).
  - No valid requester: remain in IDLE.
- Effective length: req_len of 0 or > MAX_BURST sets err and is treated as 1.
- XFER: busy=1.
  - req_ready[gnt_id] = !fifo_full; all other ready bits 0.
  - fifo_wen = req_valid[gnt_id] & req_ready[gnt_id] (combinational).
  - fifo_wdata = {gnt_id, eop, req_data slice}, with eop = (count == len-1).
  - Each accepted word increments count. A bubble (valid low) holds state.
  - On the accepted word with eop=1: return to IDLE and set rr_ptr = gnt_id+1 mod NUM_REQ.
- Zero-bubble packets: IDLE then XFER gives a minimum 1-cycle gap between packets. The back-to-back throughput requirement is 1 word/cycle inside a packet.
- fifo_full during XFER: stall with no write. This cannot occur under the admission rule but must be handled.
- Outside XFER, fifo_wen=0 and all req_ready=0.
- err: set when an illegal length is sampled. err_clr clears it. If set and clear occur in the same cycle, set wins.
- Reset mid-packet: FSM aborts to IDLE immediately. Any partial packet is discarded together with the FIFO, which shares reset_n.
- fifo_sp width is SPW. A value of FIFO_DEPTH means empty. Comparisons are unsigned at SPW width, with L zero-extended.

Decomposition:
- Shared package fifo_sched_pkg:
  - state enum {IDLE, XFER}
  - IDW/LENW/SPW width functions
  - field offsets of the fifo_wdata tag ({id, eop, data} MSB..LSB), which the APB-side reader also uses
- One sub-module: rr_arbiter (NUM_REQ-wide request vector plus rr_ptr in, one-hot/ID winner out, purely combinational priority rotate).

Test Plan:
1. Single requester 0, len=3, data 0xA0..0xA2, fifo_sp=16 -> 3 fifo_wen pulses on consecutive cycles after 1-cycle grant; wdata tags {0,0,A0},{0,0,A1},{0,1,A2}; busy drops after the third word.
2. All 4 requesters valid, len=1 each, repeated -> grant order 0,1,2,3,0; rr_ptr wraps; no requester is granted twice before the others.
3. Requester 1 len=8 with fifo_sp=5, requester 2 len=1 also valid, rr_ptr=1 -> no grant and requester 2 not served; when fifo_sp rises to 8, requester 1 is granted and its 8 words are written.
4. req_len=0 on requester 3 -> err=1, a single word is written with eop=1; err_clr pulse -> err=0; err_clr coincident with a new illegal length -> err stays 1.
5. Mid-packet valid bubble (len=4, valid low for 2 cycles after word 1) -> no fifo_wen during the bubble, count holds, eop only on word 4.
6. reset_n asserted after word 2 of a len=6 packet -> outputs are reset values immediately; after release, state=IDLE and rr_ptr=0, and the next grant goes to the lowest valid ID.

Source files
------------

// File: rtl/fifo_sched_pkg.sv
// Shared types, width helpers and FIFO word tag layout for the write-side scheduler
// and the APB-side reader.
package fifo_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int unsigned idw(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned lenw(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  function automatic int unsigned spw(input int unsigned fifo_depth);
    return $clog2(fifo_depth) + 1;
  endfunction

  // FIFO word layout, MSB..LSB: {id, eop, data}
  localparam int unsigned DATA_LSB = 0;

  function automatic int unsigned eop_pos(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned id_lsb(input int unsigned data_width);
    return data_width + 1;
  endfunction

  function automatic int unsigned wdata_w(input int unsigned data_width, input int unsigned num_req);
    return data_width + idw(num_req) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Requester and FIFO write-port bundle of the write-side scheduler.
interface fifo_wr_sched_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 16
);
  import fifo_sched_pkg::*;

  localparam int unsigned LENW = lenw(MAX_BURST);
  localparam int unsigned SPW  = spw(FIFO_DEPTH);
  localparam int unsigned WW   = wdata_w(DATA_WIDTH, NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*LENW-1:0]       req_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic [SPW-1:0]                fifo_sp;
  logic                          fifo_wen;
  logic [WW-1:0]                 fifo_wdata;

  modport master (
    output req_valid, req_len, req_data, fifo_full, fifo_sp,
    input  req_ready, fifo_wen, fifo_wdata
  );

  modport slave (
    input  req_valid, req_len, req_data, fifo_full, fifo_sp,
    output req_ready, fifo_wen, fifo_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        req,
  input  logic [idw(NUM_REQ)-1:0]   ptr,
  output logic                      gnt_valid,
  output logic [idw(NUM_REQ)-1:0]   gnt_id
);

  localparam int unsigned IDW = idw(NUM_REQ);
  localparam int unsigned SW  = IDW + 1;

  logic [SW-1:0]  sum;
  logic [IDW-1:0] idx;

  // Scan from farthest to nearest offset so the nearest valid request wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = IDW'(sum);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Write-side FIFO scheduler: round-robin packet admission on free space, then
// one word per cycle tagged {id, eop, data} until end of packet.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                    wclk,
  input  logic                    reset_n,
  fifo_wr_sched_if.slave          bus,
  input  logic                    err_clr,
  output logic [idw(NUM_REQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned IDW  = idw(NUM_REQ);
  localparam int unsigned LENW = lenw(MAX_BURST);
  localparam int unsigned SPW  = spw(FIFO_DEPTH);
  localparam int unsigned WW   = wdata_w(DATA_WIDTH, NUM_REQ);

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_q, rr_d, gnt_q, gnt_d, win_id;
  logic [LENW-1:0]       len_q, len_d, cnt_q, cnt_d, win_len, eff_len;
  logic                  err_q, err_d;
  logic                  win_valid, illegal, admit, eop;
  logic [NUM_REQ-1:0]    ready_c;
  logic                  wen_c;
  logic [WW-1:0]         wdata_c;
  logic [DATA_WIDTH-1:0] gnt_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_q),
    .gnt_valid (win_valid),
    .gnt_id    (win_id)
  );

  // Length of the candidate and payload of the granted requester.
  always_comb begin
    win_len  = '0;
    gnt_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (IDW'(i) == win_id) win_len  = bus.req_len[i*LENW +: LENW];
      if (IDW'(i) == gnt_q)  gnt_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign illegal = (win_len == '0) || (win_len > LENW'(MAX_BURST));
  assign eff_len = illegal ? LENW'(1) : win_len;
  assign admit   = win_valid && (SPW'(eff_len) <= bus.fifo_sp);
  assign eop     = (cnt_q == len_q - LENW'(1));

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q & ~err_clr;
    ready_c = '0;
    wen_c   = 1'b0;
    wdata_c = '0;
    case (state_q)
      IDLE: begin
        // The candidate waits for space; smaller packets never overtake it.
        if (admit) begin
          state_d = XFER;
          gnt_d   = win_id;
          len_d   = eff_len;
          cnt_d   = '0;
          if (illegal) err_d = 1'b1;
        end
      end
      XFER: begin
        ready_c[gnt_q] = ~bus.fifo_full;
        wen_c          = bus.req_valid[gnt_q] & ~bus.fifo_full;
        wdata_c        = {gnt_q, eop, gnt_data};
        if (wen_c) begin
          cnt_d = cnt_q + LENW'(1);
          if (eop) begin
            state_d = IDLE;
            rr_d    = (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + IDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = ready_c;
  assign bus.fifo_wen   = wen_c;
  assign bus.fifo_wdata = wdata_c;
  assign gnt_id         = gnt_q;
  assign busy           = (state_q == XFER);
  assign err            = err_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Self-checking bench for fifo_wr_sched: requester models feed packets, a queue of
// expected FIFO words is checked against every write.
module tb_fifo_wr_sched;
  import fifo_sched_pkg::*;

  localparam int unsigned NR   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned FD   = 16;
  localparam int unsigned MB   = 16;
  localparam int unsigned IDW  = idw(NR);
  localparam int unsigned LENW = lenw(MB);
  localparam int unsigned SPW  = spw(FD);
  localparam int unsigned WW   = wdata_w(DW, NR);

  logic           wclk    = 1'b0;
  logic           reset_n = 1'b0;
  logic           err_clr = 1'b0;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           err;

  fifo_wr_sched_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(MB)) bus ();

  fifo_wr_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(MB)) dut (
    .wclk    (wclk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .err_clr (err_clr),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .err     (err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    int unsigned id;
    int unsigned len_raw;
    int unsigned sp;
    int unsigned words;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[7];
  logic [WW-1:0] exp_q[$];
  int unsigned src_len[NR], src_plen[NR], src_cnt[NR];
  logic [DW-1:0] src_base[NR];
  bit          src_act[NR], src_bub[NR];
  int          tests = 0;
  int          fails = 0;
  bit          last_wen, last_busy;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NR); i++) begin
      bus.req_valid[i]           = src_act[i] && !src_bub[i];
      bus.req_len[i*LENW +: LENW] = LENW'(src_len[i]);
      bus.req_data[i*DW +: DW]   = src_base[i] + DW'(src_cnt[i]);
    end
  endtask

  function automatic bit src_any();
    bit a = 1'b0;
    for (int i = 0; i < int'(NR); i++) a |= src_act[i];
    return a;
  endfunction

  // One cycle: sample at negedge, then advance the requester models after the edge.
  task automatic tick();
    logic [NR-1:0] hs;
    logic [WW-1:0] e;
    @(negedge wclk);
    last_wen  = bus.fifo_wen;
    last_busy = busy;
    if (bus.fifo_wen) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %0h expected no write", bus.fifo_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wdata", 64'(bus.fifo_wdata), 64'(e));
      end
    end
    hs = bus.req_valid & bus.req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (hs[i]) begin
        src_cnt[i]++;
        if (src_cnt[i] == src_plen[i]) src_act[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic start(input int unsigned id, input int unsigned len_raw,
                       input logic [DW-1:0] base, input int unsigned words);
    src_len[id]  = len_raw;
    src_plen[id] = words;
    src_base[id] = base;
    src_cnt[id]  = 0;
    src_act[id]  = 1'b1;
    src_bub[id]  = 1'b0;
    for (int k = 0; k < int'(words); k++)
      exp_q.push_back({IDW'(id), (k == int'(words) - 1), base + DW'(k)});
    drive();
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((src_any() || busy) && n < limit) begin
      tick();
      n++;
    end
    if (src_any() || busy) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy=%0b pending=%0d expected idle within %0d cycles", busy, exp_q.size(), limit);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{id: 0, len_raw: 3,  sp: 16, words: 3,  exp_err: 1'b0};
    tbl[1] = '{id: 2, len_raw: 16, sp: 16, words: 16, exp_err: 1'b0};
    tbl[2] = '{id: 3, len_raw: 0,  sp: 16, words: 1,  exp_err: 1'b1};
    tbl[3] = '{id: 1, len_raw: 17, sp: 16, words: 1,  exp_err: 1'b1};
    tbl[4] = '{id: 1, len_raw: 31, sp: 1,  words: 1,  exp_err: 1'b1};
    tbl[5] = '{id: 0, len_raw: 5,  sp: 5,  words: 5,  exp_err: 1'b0};
    tbl[6] = '{id: 2, len_raw: 1,  sp: 1,  words: 1,  exp_err: 1'b0};

    for (int i = 0; i < int'(NR); i++) begin
      src_len[i] = 0; src_plen[i] = 0; src_cnt[i] = 0;
      src_base[i] = '0; src_act[i] = 1'b0; src_bub[i] = 1'b0;
    end
    bus.req_valid = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    bus.fifo_sp   = SPW'(16);

    // Reset values
    repeat (2) @(posedge wclk);
    #1;
    check("rst_wen",   64'(bus.fifo_wen),   64'(0));
    check("rst_ready", 64'(bus.req_ready),  64'(0));
    check("rst_wdata", 64'(bus.fifo_wdata), 64'(0));
    check("rst_gnt",   64'(gnt_id),         64'(0));
    check("rst_busy",  64'(busy),           64'(0));
    check("rst_err",   64'(err),            64'(0));
    reset_n = 1'b1;
    tick();

    // Single packet: 1-cycle grant latency, three back-to-back words
    start(0, 3, 32'hA0, 3);
    tick();
    check("lat_wen",  64'(last_wen),  64'(0));
    check("lat_busy", 64'(last_busy), 64'(0));
    tick();
    check("w0_wen",   64'(last_wen),  64'(1));
    check("w0_gnt",   64'(gnt_id),    64'(0));
    tick();
    check("w1_wen",   64'(last_wen),  64'(1));
    tick();
    check("w2_wen",   64'(last_wen),  64'(1));
    tick();
    check("post_busy", 64'(last_busy), 64'(0));
    check("post_wen",  64'(last_wen),  64'(0));

    // Insufficient space blocks the candidate and everyone behind it
    bus.fifo_sp = SPW'(5);
    start(1, 8, 32'hB0, 8);
    start(2, 1, 32'hC0, 1);
    repeat (4) begin
      tick();
      check("nospace_wen",  64'(last_wen),  64'(0));
      check("nospace_busy", 64'(last_busy), 64'(0));
    end
    bus.fifo_sp = SPW'(8);
    wait_idle(40);
    bus.fifo_sp = SPW'(16);

    // Illegal length, clear, and set-beats-clear
    start(3, 0, 32'hD0, 1);
    wait_idle(10);
    check("err_set", 64'(err), 64'(1));
    clear_err();
    check("err_clr", 64'(err), 64'(0));
    err_clr = 1'b1;
    start(3, 0, 32'hD8, 1);
    tick();
    err_clr = 1'b0;
    check("err_set_wins", 64'(err), 64'(1));
    wait_idle(10);
    clear_err();

    // Valid bubble inside a packet
    start(0, 4, 32'hE0, 4);
    n = 0;
    while (src_cnt[0] < 1 && n < 20) begin tick(); n++; end
    src_bub[0] = 1'b1;
    drive();
    repeat (2) begin
      tick();
      check("bubble_wen",  64'(last_wen),  64'(0));
      check("bubble_busy", 64'(last_busy), 64'(1));
    end
    src_bub[0] = 1'b0;
    drive();
    wait_idle(20);

    // FIFO full while transferring stalls without writing
    start(1, 2, 32'hF0, 2);
    tick();
    bus.fifo_full = 1'b1;
    repeat (2) begin
      tick();
      check("full_wen",   64'(last_wen),      64'(0));
      check("full_ready", 64'(bus.req_ready), 64'(0));
      check("full_busy",  64'(busy),          64'(1));
    end
    bus.fifo_full = 1'b0;
    wait_idle(20);

    // Reset in the middle of a packet
    start(2, 6, 32'h60, 6);
    n = 0;
    while (src_cnt[2] < 2 && n < 20) begin tick(); n++; end
    reset_n = 1'b0;
    #1;
    check("mid_rst_wen",   64'(bus.fifo_wen),   64'(0));
    check("mid_rst_ready", 64'(bus.req_ready),  64'(0));
    check("mid_rst_wdata", 64'(bus.fifo_wdata), 64'(0));
    check("mid_rst_busy",  64'(busy),           64'(0));
    check("mid_rst_gnt",   64'(gnt_id),         64'(0));
    check("mid_rst_left",  64'(exp_q.size()),   64'(4));
    exp_q.delete();
    src_act[2] = 1'b0;
    start(1, 1, 32'h71, 1);
    start(3, 1, 32'h73, 1);
    tick();
    reset_n = 1'b1;
    wait_idle(20);

    // All requesters, single-word packets: strict 0,1,2,3 rotation twice
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < int'(NR); i++)
        start(i, 1, DW'(32'h100 + 16 * rep + i), 1);
      wait_idle(30);
    end

    // Table of single-packet vectors
    for (int v = 0; v < 7; v++) begin
      bus.fifo_sp = SPW'(tbl[v].sp);
      start(tbl[v].id, tbl[v].len_raw, DW'(32'h1000 * (v + 1)), tbl[v].words);
      wait_idle(60);
      check("tbl_err", 64'(err), 64'(tbl[v].exp_err));
      clear_err();
      check("tbl_err_clr", 64'(err), 64'(0));
    end

    check("leftover_words", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
